// File: rtl/coin_pkg.sv
// Shared coin/debounce encodings and coin values for the coin acceptor.
// The audit counter is built only when COIN_AUDIT_EN is defined.
package coin_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      C10  = 2'd1,
      C50  = 2'd2
   } coin_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HELD  = 2'd2
   } db_state_t;

   localparam logic [15:0] C10_VALUE = 16'd1;
   localparam logic [15:0] C50_VALUE = 16'd5;

   function automatic logic [15:0] coin_value(coin_t c);
      case (c)
         C10:     coin_value = C10_VALUE;
         C50:     coin_value = C50_VALUE;
         default: coin_value = '0;
      endcase
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// Per-channel 2-flop synchroniser and debounce FSM.
// Raises qualify_o for exactly one cycle per coin insertion.
module coin_debounce
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic qualify_o
);

   localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

   logic [1:0] sync_q;
   logic       synced;
   db_state_t  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   assign synced = sync_q[1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q holds the number of consecutive highs already seen
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      qualify_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (synced) begin
               state_d = COUNT;
               cnt_d   = 4'd1;
            end
         end
         COUNT: begin
            if (!synced) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d   = HELD;
               cnt_d     = '0;
               qualify_o = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HELD: begin
            if (!synced) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced channels, accepted-coin FIFO, paced pulses.
// Define COIN_AUDIT_EN to build the audit_total counter.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        coin_10_raw,
   input  logic        coin_50_raw,
   input  logic        accept_en,
   output logic        dollar_10,
   output logic        dollar_50,
   output logic        coin_reject,
   output logic [3:0]  fifo_count,
   output logic [15:0] audit_total
);

   localparam int         PW   = $clog2(FIFO_DEPTH);
   localparam logic [3:0] FULL = 4'(FIFO_DEPTH);

   logic q10, q50;

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db10 (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (coin_10_raw),
      .qualify_o(q10)
   );

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db50 (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (coin_50_raw),
      .qualify_o(q50)
   );

   coin_t          mem_q [FIFO_DEPTH];
   logic [PW-1:0]  wr_q, rd_q;
   logic [3:0]     cnt_q, cnt_d;
   logic           d10_q, d50_q, rej_q;
   logic           one_coin, full, push, pop, rej_d;
   coin_t          in_coin, head;

   assign one_coin = q10 ^ q50;
   assign in_coin  = q10 ? C10 : C50;
   assign full     = (cnt_q == FULL);
   assign head     = mem_q[rd_q];

   // A pulse in flight blocks the next pop, giving an idle gap
   assign pop   = accept_en && (cnt_q != 4'd0) && !(d10_q || d50_q);
   assign push  = one_coin && (!full || pop);
   assign rej_d = (q10 && q50) || (one_coin && !push);
   assign cnt_d = cnt_q + {3'b0, push} - {3'b0, pop};

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         d10_q <= 1'b0;
         d50_q <= 1'b0;
         rej_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= in_coin;
            wr_q        <= wr_q + PW'(1);
         end
         if (pop) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_d;
         d10_q <= pop && (head == C10);
         d50_q <= pop && (head == C50);
         rej_q <= rej_d;
      end
   end

   assign dollar_10   = d10_q;
   assign dollar_50   = d50_q;
   assign coin_reject = rej_q;
   assign fifo_count  = cnt_q;

`ifdef COIN_AUDIT_EN
   logic [15:0] audit_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         audit_q <= '0;
      end else if (pop) begin
         audit_q <= audit_q + coin_value(head);
      end
   end

   assign audit_total = audit_q;
`else
   assign audit_total = '0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: per-cycle vector table
// plus hand-written FIFO, reset and audit sequences.
`timescale 1ns/1ps
module tb_coin_acceptor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        coin_10_raw = 1'b0;
   logic        coin_50_raw = 1'b0;
   logic        accept_en = 1'b0;
   logic        dollar_10, dollar_50, coin_reject;
   logic [3:0]  fifo_count;
   logic [15:0] audit_total;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int n10 = 0, n50 = 0, nrej = 0, nboth = 0;
   int plog_cyc[$];
   int plog_val[$];

   coin_acceptor dut (
      .clk        (clk),
      .reset      (reset),
      .coin_10_raw(coin_10_raw),
      .coin_50_raw(coin_50_raw),
      .accept_en  (accept_en),
      .dollar_10  (dollar_10),
      .dollar_50  (dollar_50),
      .coin_reject(coin_reject),
      .fifo_count (fifo_count),
      .audit_total(audit_total)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       rst, c10, c50, acc;
      bit       d10, d50, rej;
      bit [3:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, bit c10, bit c50, bit acc,
                               bit d10, bit d50, bit rej, int cnt);
      vec_t v;
      v.rst = rst; v.c10 = c10; v.c50 = c50; v.acc = acc;
      v.d10 = d10; v.d50 = d50; v.rej = rej; v.cnt = 4'(cnt);
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (dollar_10) begin
         n10++;
         plog_cyc.push_back(cyc);
         plog_val.push_back(10);
      end
      if (dollar_50) begin
         n50++;
         plog_cyc.push_back(cyc);
         plog_val.push_back(50);
      end
      if (dollar_10 && dollar_50) nboth++;
      if (coin_reject) nrej++;
   endtask

   task automatic check(string name, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic clear_logs();
      n10 = 0; n50 = 0; nrej = 0; nboth = 0;
      plog_cyc.delete();
      plog_val.delete();
   endtask

   task automatic insert(bit is50);
      coin_10_raw = !is50;
      coin_50_raw = is50;
      repeat (6) tick();
      coin_10_raw = 1'b0;
      coin_50_raw = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      // reset
      repeat (2) add(0, 0, 0, 1, 0, 0, 0, 0);
      // C10 held 10 cycles: queued on 6th edge, pulse on 7th
      repeat (5) add(1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 1, 0, 0, 0, 1);
      add(1, 1, 0, 1, 1, 0, 0, 0);
      repeat (3) add(1, 1, 0, 1, 0, 0, 0, 0);
      repeat (4) add(1, 0, 0, 1, 0, 0, 0, 0);
      // C50 glitch of 3 cycles: never qualifies
      repeat (3) add(1, 0, 1, 1, 0, 0, 0, 0);
      repeat (7) add(1, 0, 0, 1, 0, 0, 0, 0);
      // both channels together: single reject, nothing queued
      repeat (5) add(1, 1, 1, 1, 0, 0, 0, 0);
      add(1, 1, 1, 1, 0, 0, 1, 0);
      repeat (6) add(1, 0, 0, 1, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         reset       = vecs[i].rst;
         coin_10_raw = vecs[i].c10;
         coin_50_raw = vecs[i].c50;
         accept_en   = vecs[i].acc;
         tick();
         checks++;
         if ({dollar_10, dollar_50, coin_reject, fifo_count} ==
             {vecs[i].d10, vecs[i].d50, vecs[i].rej, vecs[i].cnt})
            passed++;
         else
            $display("FAIL vec%0d: got d10=%b d50=%b rej=%b cnt=%0d, exp d10=%b d50=%b rej=%b cnt=%0d",
                     i, dollar_10, dollar_50, coin_reject, fifo_count,
                     vecs[i].d10, vecs[i].d50, vecs[i].rej, vecs[i].cnt);
      end

      // FIFO fill, overflow reject, then ordered drain
      accept_en = 1'b0;
      clear_logs();
      insert(0); insert(1); insert(0); insert(1);
      check("fill_count", fifo_count, 4);
      check("fill_rej", nrej, 0);
      insert(0);
      check("ovf_count", fifo_count, 4);
      check("ovf_rej", nrej, 1);
      check("held_pulses", n10 + n50, 0);
      accept_en = 1'b1;
      plog_cyc.delete();
      plog_val.delete();
      repeat (12) tick();
      check("drain_n", plog_val.size(), 4);
      if (plog_val.size() == 4) begin
         check("drain_0", plog_val[0], 10);
         check("drain_1", plog_val[1], 50);
         check("drain_2", plog_val[2], 10);
         check("drain_3", plog_val[3], 50);
         for (int i = 1; i < 4; i++)
            check("drain_gap", plog_cyc[i] - plog_cyc[i-1], 2);
      end
      check("drain_both", nboth, 0);
      check("drain_count", fifo_count, 0);

      // reset with two queued coins and one mid-debounce
      accept_en = 1'b0;
      insert(0); insert(1);
      check("pre_rst_count", fifo_count, 2);
      coin_10_raw = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      coin_10_raw = 1'b0;
      tick();
      check("rst_d10", dollar_10, 0);
      check("rst_d50", dollar_50, 0);
      check("rst_rej", coin_reject, 0);
      check("rst_count", fifo_count, 0);
      check("rst_audit", audit_total, 0);
      reset = 1'b1;
      accept_en = 1'b1;
      clear_logs();
      repeat (15) tick();
      check("post_rst_pulses", n10 + n50, 0);
      check("post_rst_rej", nrej, 0);
      check("post_rst_count", fifo_count, 0);
      insert(1);
      check("new_coin_d50", n50, 1);
      check("new_coin_d10", n10, 0);

`ifdef COIN_AUDIT_EN
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("audit_rst", audit_total, 0);
      clear_logs();
      for (int k = 0; k < 13107; k++) begin
         coin_50_raw = 1'b1;
         repeat (4) tick();
         coin_50_raw = 1'b0;
         tick();
      end
      repeat (10) tick();
      check("audit_n50", n50, 13107);
      check("audit_max", audit_total, 65535);
      insert(0);
      check("audit_wrap", audit_total, 0);
`else
      check("audit_off", audit_total, 0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
